// File: rtl/lc3b_pkg.sv
// Shared LC-3b widths and the MAR queue entry format.
// With AGU_ALIGN_CHECK_EN the entry carries a misaligned-word flag; otherwise it is the address alone.
package lc3b_pkg;

    localparam int WORD_W     = 16;
    localparam int TRAPVECT_W = 8;

`ifdef AGU_ALIGN_CHECK_EN
    typedef struct packed {
        logic [WORD_W-1:0] addr;
        logic              unaligned;
    } entry_t;
`else
    typedef struct packed {
        logic [WORD_W-1:0] addr;
    } entry_t;
`endif

endpackage

// File: rtl/agu_mar_if.sv
// Request/response bundle between decode, the AGU/MAR stage and memory control.
// The slave modport is the AGU side; the master modport drives requests and consumes MAR entries.
interface agu_mar_if #(
    parameter int WORD_W     = lc3b_pkg::WORD_W,
    parameter int TRAPVECT_W = lc3b_pkg::TRAPVECT_W
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_W-1:0]     base;
    logic [WORD_W-1:0]     offset;
    logic                  lshf1_en;
    logic                  trap_sel;
    logic [TRAPVECT_W-1:0] trapvect;
    logic                  word_access;
    logic                  out_valid;
    logic                  out_ready;
    logic [WORD_W-1:0]     mar;
    logic                  unaligned;

    modport master (
        output in_valid, base, offset, lshf1_en, trap_sel, trapvect, word_access, out_ready,
        input  in_ready, out_valid, mar, unaligned
    );

    modport slave (
        input  in_valid, base, offset, lshf1_en, trap_sel, trapvect, word_access, out_ready,
        output in_ready, out_valid, mar, unaligned
    );
endinterface

// File: rtl/agu_fifo2.sv
// Two-entry in-order FIFO of MAR entries with 1-bit toggling read/write pointers.
// Latency: a push is visible at the output the cycle after it is accepted.
// Backpressure: in_ready drops at count 2; a pop does not free space in the same cycle.
module agu_fifo2
    import lc3b_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   in_valid,
    output logic   in_ready,
    input  entry_t in_dat,
    output logic   out_valid,
    input  logic   out_ready,
    output entry_t out_dat
);

    entry_t     entry0_q, entry0_d;
    entry_t     entry1_q, entry1_d;
    logic [1:0] count_q,  count_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic       push, pop, head_sel;

    assign in_ready  = (count_q < 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Entries are never cleared on pop, so when empty the slot behind rd_ptr still
    // holds the last popped entry (or zero after reset).
    assign head_sel = (count_q == 2'd0) ? ~rd_ptr_q : rd_ptr_q;
    assign out_dat  = head_sel ? entry1_q : entry0_q;

    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
        if (push) begin
            if (wr_ptr_q) begin
                entry1_d = in_dat;
            end else begin
                entry0_d = in_dat;
            end
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/agu_mar.sv
// LC-3b address generation into a 2-deep MAR queue; optional misalignment flag under AGU_ALIGN_CHECK_EN.
// Latency: 1 cycle from accept to out_valid.
// Backpressure: in_ready low while two entries are queued, regardless of out_ready.
module agu_mar #(
    parameter int WORD_W     = lc3b_pkg::WORD_W,
    parameter int TRAPVECT_W = lc3b_pkg::TRAPVECT_W
) (
    input logic      clk,
    input logic      rst_n,
    agu_mar_if.slave bus
);

    logic [WORD_W-1:0] off_sh;
    logic [WORD_W-1:0] addr;
    lc3b_pkg::entry_t  push_dat;
    lc3b_pkg::entry_t  head_dat;

    always_comb begin
        off_sh = bus.lshf1_en ? {bus.offset[WORD_W-2:0], 1'b0} : bus.offset;
        if (bus.trap_sel) begin
            addr = {{(WORD_W-TRAPVECT_W-1){1'b0}}, bus.trapvect, 1'b0};
        end else begin
            addr = bus.base + off_sh;
        end
        push_dat      = '0;
        push_dat.addr = addr;
`ifdef AGU_ALIGN_CHECK_EN
        push_dat.unaligned = bus.word_access & addr[0];
`endif
    end

    agu_fifo2 u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_dat    (push_dat),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_dat   (head_dat)
    );

    assign bus.mar = head_dat.addr;

`ifdef AGU_ALIGN_CHECK_EN
    assign bus.unaligned = head_dat.unaligned;
`else
    logic unused_word_access;
    assign unused_word_access = bus.word_access;
    assign bus.unaligned      = 1'b0;
`endif

endmodule

// File: doc/agu_mar.md
AGU_MAR -- requirements
Module: agu_mar

Interface
REQ-001 Parameter: WORD_W, 16, datapath and address width.
REQ-002 Parameter: TRAPVECT_W, 8, trap vector field width.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  input  1  request present on input side.
REQ-006 Port: in_ready  output  1  stage can accept a request this cycle.
REQ-007 Port: base  input  WORD_W  base operand (BaseR or PC) for the address adder.
REQ-008 Port: offset  input  WORD_W  sign-extended offset from the SEXT stage.
REQ-009 Port: lshf1_en  input  1  1 = offset shifted left by one before the add (word scaling).
REQ-010 Port: trap_sel  input  1  1 = address taken from the trap vector instead of the adder.
REQ-011 Port: trapvect  input  TRAPVECT_W  trap vector field of the instruction.
REQ-012 Port: word_access  input  1  1 = request is a word (16-bit) memory access.
REQ-013 Port: out_valid  output  1  MAR entry available to memory control.
REQ-014 Port: out_ready  input  1  memory control consumes head entry this cycle.
REQ-015 Port: mar  output  WORD_W  address of head entry.
REQ-016 Port: unaligned  output  1  head entry is a misaligned word access.

Function
REQ-017 Address computation: trap_sel=1 -> zero-extended trapvect << 1; else base + (lshf1_en ? offset << 1 : offset), truncated modulo 2^WORD_W, carry discarded.
REQ-018 Shift discards offset bit 15 and inserts 0 at bit 0.
REQ-019 Accept: in_valid & in_ready in cycle N; computed address is captured at the edge ending cycle N; out_valid=1 in cycle N+1 (latency 1).
REQ-020 Buffer: 2-entry FIFO, in order; occupancy count 0..2.
REQ-021 in_ready = (count < 2); no pass-through when full, even if out_ready=1 that cycle.
REQ-022 Pop: out_valid & out_ready removes head; next entry (if any) is presented in the following cycle.
REQ-023 Simultaneous push and pop at count=1: count stays 1, new entry becomes head.
REQ-024 out_valid = (count > 0); mar/unaligned hold stable while out_valid & !out_ready.
REQ-025 When count=0, mar holds the last popped value (0 if none since reset).
REQ-026 Pointer wrap: read/write pointers are 1 bit and toggle on pop/push respectively.

Reset
REQ-027 rst_n low asynchronously clears count, both pointers, both entries; out_valid=0, mar=0, unaligned=0, in_ready=1.
REQ-028 Reset mid-operation discards all buffered entries; no entry is presented after reset release.
REQ-029 First accept possible in the first rising edge with rst_n high.

Configuration
REQ-030 Macro AGU_ALIGN_CHECK_EN defined: each entry stores unaligned = word_access & address[0], captured with the address.
REQ-031 Macro undefined: no storage bit; unaligned port exists and is constant 0; address path unchanged.

Structure
REQ-032 Shared package lc3b_pkg holds WORD_W, TRAPVECT_W defaults and the entry typedef (address plus unaligned flag).
REQ-033 One sub-module agu_fifo2: 2-entry FIFO with count, pointers, in_ready/out_valid; agu_mar holds the adder, shift, trap mux and alignment check.

Verification
REQ-034 base=0x3000, offset=0xFFFE, lshf1_en=1, trap_sel=0, out_ready=1 -> next cycle out_valid=1, mar=0x2FFC.
REQ-035 trap_sel=1, trapvect=0x25, base=0xFFFF -> mar=0x004A, unaligned=0.
REQ-036 out_ready=0, three back-to-back requests -> two accepted, in_ready=0 on third cycle; out_ready=1 for one cycle -> mar advances to second entry, in_ready=1.
REQ-037 count=1, push and pop same cycle -> count stays 1, mar shows pushed address next cycle.
REQ-038 With AGU_ALIGN_CHECK_EN: base=0x4001, offset=0, lshf1_en=0, word_access=1 -> mar=0x4001, unaligned=1; without macro -> unaligned=0.
REQ-039 Assert rst_n low mid-cycle with count=2 -> out_valid=0, mar=0, in_ready=1 immediately, before the next edge.
